axis_rr_arbiter: RTL and testbench

- N-to-1 AXI-Stream packet arbiter placed in front of the existing single-input AXIS byte sink.
- Shares that sink between NUM_SRC upstream masters using round-robin.
- Locks the grant for a whole packet, through the beat carrying tlast.
- Forwards data combinationally from the granted source, so the sink's handshake is unchanged.

---
 rtl/axis_arb_pkg.sv | 12 +
 rtl/rr_pick.sv | 28 ++
 rtl/axis_rr_arbiter.sv | 102 ++++++++++
 tb/tb_axis_rr_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared arbiter state encoding and width constants
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam int PKT_CNT_W  = 16;
    localparam int DATA_W_DEF = 8;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin search: first set req bit at or after ptr, with wrap
module rr_pick #(
    parameter  int NUM_SRC = 4,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    int j;

    // Walk the offsets downward so the smallest offset from ptr is written last and wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NUM_SRC;
            if (req[j]) begin
                found = 1'b1;
                idx   = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/axis_rr_arbiter.sv
// rtl/axis_rr_arbiter.sv - N:1 AXIS packet arbiter, round-robin, grant locked through tlast; AXIS_RR_ARBITER_PKT_CNT_EN builds packet counters
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC = 4,
    parameter  int DATA_W  = DATA_W_DEF,
    localparam int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic                           s_axis_clk,
    input  logic                           s_axis_reset,
    input  logic [NUM_SRC-1:0]             s_axis_tvalid,
    input  logic [NUM_SRC*DATA_W-1:0]      s_axis_tdata,
    input  logic [NUM_SRC-1:0]             s_axis_tlast,
    output logic [NUM_SRC-1:0]             s_axis_tready,
    output logic                           m_axis_tvalid,
    output logic [DATA_W-1:0]              m_axis_tdata,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic [NUM_SRC-1:0]             grant,
    output logic                           busy,
    output logic [NUM_SRC*PKT_CNT_W-1:0]   pkt_cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             pkt_done;

    rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req   (s_axis_tvalid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign busy     = (state == LOCK);
    assign pkt_done = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state == LOCK) begin
            m_axis_tvalid      = s_axis_tvalid[sel];
            m_axis_tdata       = s_axis_tdata[sel*DATA_W +: DATA_W];
            m_axis_tlast       = s_axis_tlast[sel];
            s_axis_tready[sel] = m_axis_tready;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_found) state_nxt = LOCK;
            LOCK:    if (pkt_done)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_clk) begin
        if (s_axis_reset) begin
            state  <= IDLE;
            sel    <= '0;
            rr_ptr <= '0;
            grant  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_found) begin
                sel   <= pick_idx;
                grant <= NUM_SRC'(1) << pick_idx;
            end
            // Pointer only moves on a completed packet so a stalled or gapped packet keeps its turn.
            if (pkt_done) begin
                rr_ptr <= (sel == SEL_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;
                grant  <= '0;
            end
        end
    end

`ifdef AXIS_RR_ARBITER_PKT_CNT_EN
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt
        logic [PKT_CNT_W-1:0] cnt_q;

        always_ff @(posedge s_axis_clk) begin
            if (s_axis_reset) begin
                cnt_q <= '0;
            end else if (pkt_done && sel == SEL_W'(i) && cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign pkt_cnt[i*PKT_CNT_W +: PKT_CNT_W] = cnt_q;
    end
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// tb/tb_axis_rr_arbiter.sv - directed self-checking bench for axis_rr_arbiter (NUM_SRC=4, DATA_W=8)
module tb_axis_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  s_tvalid;
    logic [31:0] s_tdata;
    logic [3:0]  s_tlast;
    logic [3:0]  s_tready;
    logic        m_tvalid;
    logic [7:0]  m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic [3:0]  grant;
    logic        busy;
    logic [63:0] pkt_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    axis_rr_arbiter #(.NUM_SRC(4), .DATA_W(8)) dut (
        .s_axis_clk    (clk),
        .s_axis_reset  (reset),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .grant         (grant),
        .busy          (busy),
        .pkt_cnt       (pkt_cnt)
    );

    // Leaves the caller just after a negedge with the DUT in IDLE and rr_ptr=0.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; s_tvalid = '0; s_tlast = '0; s_tdata = '0; m_tready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_tvalid = 4'hF; s_tlast = '0; s_tdata = 32'h3322_1100; m_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid got=%b want=0", m_tvalid); end
        total++; if (s_tready !== 4'b0000) begin bad++; $display("FAIL reset_s_tready got=%b want=0000", s_tready); end
        total++; if (m_tdata !== 8'h00) begin bad++; $display("FAIL reset_m_tdata got=%h want=00", m_tdata); end
        reset = 1'b0;
        @(negedge clk); #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL reset_first_grant got=%b want=0001", grant); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_first_busy got=%b want=1", busy); end
        total++; if (s_tready !== 4'b0001) begin bad++; $display("FAIL reset_first_tready got=%b want=0001", s_tready); end
    endtask

    task automatic test_single();
        logic [7:0] exp_d;
        do_reset();
        s_tvalid = 4'b0100; s_tdata[23:16] = 8'hA0; s_tlast = '0;
        #1;
        total++; if (busy !== 1'b0 || s_tready !== 4'b0000) begin bad++; $display("FAIL single_idle got busy=%b tready=%b want 0/0000", busy, s_tready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp_d = 8'(8'hA0 + k);
            s_tdata[23:16] = exp_d; s_tlast[2] = (k == 2);
            #1;
            total++; if (grant !== 4'b0100) begin bad++; $display("FAIL single_grant beat=%0d got=%b want=0100", k, grant); end
            total++; if (m_tdata !== exp_d || m_tlast !== (k == 2)) begin bad++; $display("FAIL single_data beat=%0d got=%h/%b want=%h/%b", k, m_tdata, m_tlast, exp_d, (k == 2)); end
            total++; if (s_tready !== 4'b0100) begin bad++; $display("FAIL single_tready beat=%0d got=%b want=0100", k, s_tready); end
        end
        @(negedge clk);
        s_tvalid = 4'b1001; s_tlast = 4'b1001; s_tdata = 32'hD300_00D0;
        #1;
        total++; if (busy !== 1'b0 || grant !== 4'b0000) begin bad++; $display("FAIL single_end got busy=%b grant=%b want 0/0000", busy, grant); end
        @(negedge clk); #1;
        total++; if (grant !== 4'b1000 || m_tdata !== 8'hD3) begin bad++; $display("FAIL single_ptr3 got grant=%b data=%h want 1000/d3", grant, m_tdata); end
        @(negedge clk);
        s_tvalid = 4'b0001;
        @(negedge clk); #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_wrap got=%b want=0001", grant); end
    endtask

    task automatic drive_all(input logic [3:0] b);
        s_tvalid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            s_tdata[i*8 +: 8] = 8'(16 * i + int'(b[i]));
            s_tlast[i]        = b[i];
        end
    endtask

    task automatic test_contention();
        logic [3:0] b;
        logic [3:0] exp_g;
        int         exp_s;
        b = '0;
        do_reset();
        for (int p = 0; p < 5; p++) begin
            exp_s = p % 4;
            exp_g = 4'(1 << exp_s);
            drive_all(b);
            #1;
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_gap pkt=%0d got busy=%b want=0", p, busy); end
            for (int k = 0; k < 2; k++) begin
                @(negedge clk);
                drive_all(b);
                #1;
                total++; if (grant !== exp_g) begin bad++; $display("FAIL cont_grant pkt=%0d got=%b want=%b", p, grant, exp_g); end
                total++; if (m_tdata !== 8'(16 * exp_s + k) || m_tlast !== k[0]) begin bad++; $display("FAIL cont_data pkt=%0d beat=%0d got=%h/%b want=%h/%b", p, k, m_tdata, m_tlast, 8'(16 * exp_s + k), k[0]); end
                b[exp_s] = ~b[exp_s];
            end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] pat;
        logic [7:0] exp_d;
        int         k;
        pat = 6'b111001;
        k   = 0;
        do_reset();
        s_tvalid = 4'b1010; s_tlast = '0; s_tdata = 32'h3F00_B000;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle got busy=%b want=0", busy); end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_d = 8'(8'hB0 + k);
            m_tready = pat[c]; s_tdata[15:8] = exp_d; s_tlast[1] = (k == 3);
            #1;
            total++; if (grant !== 4'b0010 || m_tdata !== exp_d || m_tlast !== (k == 3)) begin bad++; $display("FAIL bp_beat cyc=%0d got grant=%b data=%h last=%b want 0010/%h/%b", c, grant, m_tdata, m_tlast, exp_d, (k == 3)); end
            total++; if (s_tready !== (pat[c] ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL bp_tready cyc=%0d got=%b want=%b", c, s_tready, (pat[c] ? 4'b0010 : 4'b0000)); end
            if (pat[c]) k++;
        end
        @(negedge clk);
        s_tvalid = 4'b1000; m_tready = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || s_tready !== 4'b0000) begin bad++; $display("FAIL bp_end got busy=%b tready=%b want 0/0000", busy, s_tready); end
        @(negedge clk); #1;
        total++; if (grant !== 4'b1000 || m_tdata !== 8'h3F) begin bad++; $display("FAIL bp_next got grant=%b data=%h want 1000/3f", grant, m_tdata); end
    endtask

    task automatic test_gap_reset();
        do_reset();
        s_tvalid = 4'b0001; s_tdata[7:0] = 8'h50; s_tlast = '0; m_tready = 1'b1;
        @(negedge clk); #1;
        total++; if (grant !== 4'b0001 || m_tdata !== 8'h50) begin bad++; $display("FAIL gap_first got grant=%b data=%h want 0001/50", grant, m_tdata); end
        for (int g = 0; g < 2; g++) begin
            @(negedge clk);
            s_tvalid = 4'b0010;
            #1;
            total++; if (busy !== 1'b1 || grant !== 4'b0001 || m_tvalid !== 1'b0 || s_tready !== 4'b0001) begin bad++; $display("FAIL gap_hold cyc=%0d got busy=%b grant=%b mv=%b tready=%b want 1/0001/0/0001", g, busy, grant, m_tvalid, s_tready); end
        end
        @(negedge clk);
        s_tvalid = 4'b0011; s_tdata[7:0] = 8'h51;
        #1;
        total++; if (grant !== 4'b0001 || m_tdata !== 8'h51) begin bad++; $display("FAIL gap_resume got grant=%b data=%h want 0001/51", grant, m_tdata); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        total++; if (busy !== 1'b0 || grant !== 4'b0000 || m_tvalid !== 1'b0) begin bad++; $display("FAIL gap_reset got busy=%b grant=%b mv=%b want 0/0000/0", busy, grant, m_tvalid); end
        total++; if (pkt_cnt !== 64'h0) begin bad++; $display("FAIL gap_reset_cnt got=%h want=0", pkt_cnt); end
        reset = 1'b0;
        @(negedge clk); #1;
        total++; if (grant !== 4'b0001) begin bad++; $display("FAIL gap_after_reset got=%b want=0001", grant); end
    endtask

    task automatic test_pkt_cnt();
        do_reset();
        s_tvalid = 4'b1000; s_tlast = 4'b1000; s_tdata[31:24] = 8'hC3; m_tready = 1'b1;
        repeat (6) @(negedge clk);
        s_tvalid = '0;
        #1;
`ifdef AXIS_RR_ARBITER_PKT_CNT_EN
        total++; if (pkt_cnt[63:48] !== 16'd3) begin bad++; $display("FAIL cnt_three got=%0d want=3", pkt_cnt[63:48]); end
        total++; if (pkt_cnt[47:0] !== 48'h0) begin bad++; $display("FAIL cnt_others got=%h want=0", pkt_cnt[47:0]); end
        force dut.g_cnt[3].cnt_q = 16'hFFFF;
        #1;
        release dut.g_cnt[3].cnt_q;
        s_tvalid = 4'b1000;
        repeat (2) @(negedge clk);
        s_tvalid = '0;
        #1;
        total++; if (pkt_cnt[63:48] !== 16'hFFFF) begin bad++; $display("FAIL cnt_saturate got=%h want=ffff", pkt_cnt[63:48]); end
`else
        total++; if (pkt_cnt !== 64'h0) begin bad++; $display("FAIL cnt_disabled got=%h want=0", pkt_cnt); end
`endif
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL cnt_idle got busy=%b want=0", busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_gap_reset();
        test_pkt_cnt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
